// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
package hazard_pkg;

    localparam int unsigned TAG_RW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [TAG_RW-1:0] rs1;
        logic [TAG_RW-1:0] rs2;
        logic [TAG_RW-1:0] rd;
        logic              wen;
        logic              mrd;
    } stage_tag_t;

    // MEM wins over WB; loads sitting in MEM have no data yet and are skipped.
    function automatic fwd_sel_e fwd_select(
        input logic [TAG_RW-1:0] rs,
        input logic [TAG_RW-1:0] rd_m,
        input logic              wen_m,
        input logic              mrd_m,
        input logic [TAG_RW-1:0] rd_w,
        input logic              wen_w
    );
        fwd_select = FWD_RF;
        if (wen_m && !mrd_m && rd_m != '0 && rd_m == rs)
            fwd_select = FWD_MEM;
        else if (wen_w && rd_w != '0 && rd_w == rs)
            fwd_select = FWD_WB;
    endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Destination/source tag pipeline mirroring the ID/EX, EX/MEM and MEM/WB registers.
module hazard_tag_pipe
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  stage_tag_t tag_d,
    input  logic       flush_e,
    input  logic       flush_m,
    output stage_tag_t tag_e,
    output stage_tag_t tag_m,
    output stage_tag_t tag_w
);

    stage_tag_t tag_d_n;

    // Writes to x0 are dropped at entry so later stages never see them as writers.
    always_comb begin
        tag_d_n     = tag_d;
        tag_d_n.wen = tag_d.wen & (tag_d.rd != '0);
    end

    // All stages advance every cycle; flushed stages take an all-zero bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_e <= '0;
            tag_m <= '0;
            tag_w <= '0;
        end else begin
            tag_e <= flush_e ? '0 : tag_d_n;
            if (flush_m)
                tag_m <= '0;
            else
                tag_m <= '{rs1: '0, rs2: '0, rd: tag_e.rd, wen: tag_e.wen, mrd: tag_e.mrd};
            tag_w <= '{rs1: '0, rs2: '0, rd: tag_m.rd, wen: tag_m.wen, mrd: 1'b0};
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall, redirect flush and EX-stage forwarding control for the 5-stage core.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_D,
    input  logic [REG_ADDR_W-1:0] rs2_D,
    input  logic [REG_ADDR_W-1:0] rd_D,
    input  logic                  use_rs1_D,
    input  logic                  use_rs2_D,
    input  logic                  reg_wen_D,
    input  logic                  mem_rd_D,
    input  logic                  pc_sel_M,
    output logic                  stall_F,
    output logic                  stall_D,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Flush,
    output logic                  EX_MEM_Flush,
    output logic [1:0]            fwd_a_E,
    output logic [1:0]            fwd_b_E,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    stage_tag_t tag_d, tag_e, tag_m, tag_w;
    logic       load_use, redirect;
    fwd_sel_e   fwd_a, fwd_b;
    logic       unused_tag_bits;

    assign tag_d = '{rs1: rs1_D, rs2: rs2_D, rd: rd_D, wen: reg_wen_D, mrd: mem_rd_D};

    hazard_tag_pipe u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_d   (tag_d),
        .flush_e (ID_EX_Flush),
        .flush_m (EX_MEM_Flush),
        .tag_e   (tag_e),
        .tag_m   (tag_m),
        .tag_w   (tag_w)
    );

    // Hazard detection; reset masks everything so a pending pc_sel_M cannot leak a flush.
    always_comb begin
        redirect = pc_sel_M & ~reset;
        load_use = ~reset & tag_e.mrd & tag_e.wen & (tag_e.rd != '0) &
                   ((use_rs1_D & (rs1_D == tag_e.rd)) | (use_rs2_D & (rs2_D == tag_e.rd)));
        stall_F      = load_use & ~redirect;
        stall_D      = load_use & ~redirect;
        IF_ID_Flush  = redirect;
        ID_EX_Flush  = redirect | load_use;
        EX_MEM_Flush = redirect;
    end

    // Operand source selects for the instruction currently in EX.
    always_comb begin
        fwd_a   = fwd_select(tag_e.rs1, tag_m.rd, tag_m.wen, tag_m.mrd, tag_w.rd, tag_w.wen);
        fwd_b   = fwd_select(tag_e.rs2, tag_m.rd, tag_m.wen, tag_m.mrd, tag_w.rd, tag_w.wen);
        fwd_a_E = fwd_a;
        fwd_b_E = fwd_b;
    end

    assign unused_tag_bits = ^{tag_m.rs1, tag_m.rs2, tag_w.rs1, tag_w.rs2, tag_w.mrd};

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (load_use && !redirect && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (redirect && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_D, rs2_D, rd_D;
    logic        use_rs1_D, use_rs2_D, reg_wen_D, mem_rd_D, pc_sel_M;
    logic        stall_F, stall_D, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush;
    logic [1:0]  fwd_a_E, fwd_b_E;
    logic [31:0] stall_cnt, flush_cnt;
    logic [31:0] sat_pre;

    int n_vec = 0;
    int n_bad = 0;

    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs1_D        (rs1_D),
        .rs2_D        (rs2_D),
        .rd_D         (rd_D),
        .use_rs1_D    (use_rs1_D),
        .use_rs2_D    (use_rs2_D),
        .reg_wen_D    (reg_wen_D),
        .mem_rd_D     (mem_rd_D),
        .pc_sel_M     (pc_sel_M),
        .stall_F      (stall_F),
        .stall_D      (stall_D),
        .IF_ID_Flush  (IF_ID_Flush),
        .ID_EX_Flush  (ID_EX_Flush),
        .EX_MEM_Flush (EX_MEM_Flush),
        .fwd_a_E      (fwd_a_E),
        .fwd_b_E      (fwd_b_E),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present an ID-stage instruction: {rs1, rs2, rd, use1, use2, wen, mrd}.
    task automatic drive_d(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic u1, input logic u2, input logic wen, input logic mrd);
        rs1_D = r1; rs2_D = r2; rd_D = rd;
        use_rs1_D = u1; use_rs2_D = u2; reg_wen_D = wen; mem_rd_D = mrd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hz(input string tag, input logic sf, input logic sd,
                            input logic f1, input logic f2, input logic f3);
        check({tag, "_stall_F"}, {31'b0, stall_F}, {31'b0, sf});
        check({tag, "_stall_D"}, {31'b0, stall_D}, {31'b0, sd});
        check({tag, "_IF_ID_Flush"}, {31'b0, IF_ID_Flush}, {31'b0, f1});
        check({tag, "_ID_EX_Flush"}, {31'b0, ID_EX_Flush}, {31'b0, f2});
        check({tag, "_EX_MEM_Flush"}, {31'b0, EX_MEM_Flush}, {31'b0, f3});
    endtask

    task automatic check_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        check({tag, "_fwd_a"}, {30'b0, fwd_a_E}, {30'b0, a});
        check({tag, "_fwd_b"}, {30'b0, fwd_b_E}, {30'b0, b});
    endtask

    initial begin
        reset = 1'b1;
        pc_sel_M = 1'b1;
        drive_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset: outputs held inactive even with pc_sel_M high.
        check_hz("rst", 0, 0, 0, 0, 0);
        check_fwd("rst", 2'b00, 2'b00);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);
        step();
        step();
        reset = 1'b0;
        pc_sel_M = 1'b0;

        // Load-use: lw x5 then add x6,x5,x7.
        drive_d(5'd1, 5'd0, 5'd5, 1, 0, 1, 1);
        check_hz("lu_pre", 0, 0, 0, 0, 0);
        step();
        drive_d(5'd5, 5'd7, 5'd6, 1, 1, 1, 0);
        check_hz("lu_hit", 1, 1, 0, 1, 0);
        check("lu_cnt0", stall_cnt, 32'd0);
        step();
        check_hz("lu_bubble", 0, 0, 0, 0, 0);
        check("lu_cnt1", stall_cnt, 32'd1);
        step();
        check_fwd("lu_wb", 2'b01, 2'b00);

        // ALU back-to-back: add x3 ; add x3,x1,x3 ; sub x4,x1,x3.
        drive_d(5'd1, 5'd2, 5'd3, 1, 1, 1, 0);
        step();
        drive_d(5'd1, 5'd3, 5'd3, 1, 1, 1, 0);
        check_fwd("alu_none", 2'b00, 2'b00);
        step();
        drive_d(5'd1, 5'd3, 5'd4, 1, 1, 1, 0);
        check_fwd("alu_mem", 2'b00, 2'b10);
        step();
        check_fwd("alu_mem_prio", 2'b00, 2'b10);

        // x0 writers: loads to x0 never stall, x0 never forwarded.
        drive_d(5'd1, 5'd0, 5'd0, 1, 0, 1, 1);
        step();
        drive_d(5'd0, 5'd0, 5'd0, 1, 0, 1, 1);
        check_hz("x0_nostall1", 0, 0, 0, 0, 0);
        step();
        drive_d(5'd0, 5'd0, 5'd7, 1, 1, 1, 0);
        check_hz("x0_nostall2", 0, 0, 0, 0, 0);
        step();
        check_fwd("x0_fwd", 2'b00, 2'b00);

        // Redirect and load-use together.
        drive_d(5'd0, 5'd0, 5'd8, 0, 0, 1, 1);
        step();
        pc_sel_M = 1'b1;
        drive_d(5'd8, 5'd0, 5'd9, 1, 0, 1, 0);
        check_hz("redir", 0, 0, 1, 1, 1);
        step();
        pc_sel_M = 1'b0;
        drive_d(5'd8, 5'd7, 5'd10, 1, 1, 1, 0);
        check("redir_stall_cnt", stall_cnt, 32'd1);
        check("redir_flush_cnt", flush_cnt, 32'd1);
        check_hz("redir_after", 0, 0, 0, 0, 0);
        step();
        drive_d(5'd10, 5'd10, 5'd11, 1, 1, 1, 0);
        check_fwd("redir_m_bubble", 2'b00, 2'b00);
        step();
        drive_d(5'd0, 5'd10, 5'd12, 1, 1, 1, 0);
        check_fwd("fwd_mem_both", 2'b10, 2'b10);
        step();
        check_fwd("fwd_wb_b", 2'b00, 2'b01);

        // Saturation: two load-use cycles starting from all-ones minus one.
        drive_d(5'd0, 5'd0, 5'd13, 0, 0, 1, 1);
        step();
        sat_pre = 32'hFFFF_FFFE;
        force dut.stall_cnt = sat_pre;
        #1;
        release dut.stall_cnt;
        drive_d(5'd13, 5'd0, 5'd1, 1, 0, 1, 0);
        check_hz("sat_lu1", 1, 1, 0, 1, 0);
        step();
        check("sat_reach", stall_cnt, 32'hFFFF_FFFF);
        drive_d(5'd0, 5'd0, 5'd14, 0, 0, 1, 1);
        step();
        drive_d(5'd0, 5'd14, 5'd2, 0, 1, 1, 0);
        check_hz("sat_lu2", 1, 1, 0, 1, 0);
        step();
        check("sat_hold", stall_cnt, 32'hFFFF_FFFF);

        // Async reset in the middle of a stall.
        drive_d(5'd0, 5'd0, 5'd15, 0, 0, 1, 1);
        step();
        drive_d(5'd15, 5'd0, 5'd3, 1, 0, 1, 0);
        check_hz("ar_pre", 1, 1, 0, 1, 0);
        #2;
        pc_sel_M = 1'b1;
        reset = 1'b1;
        #1;
        check_hz("ar_mid", 0, 0, 0, 0, 0);
        check("ar_stall_cnt", stall_cnt, 32'd0);
        check("ar_flush_cnt", flush_cnt, 32'd0);
        step();
        reset = 1'b0;
        pc_sel_M = 1'b0;
        #1;
        check_hz("ar_rel", 0, 0, 0, 0, 0);
        step();
        check_hz("ar_next", 0, 0, 0, 0, 0);
        check("ar_cnt_after", stall_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
